sio_fifo_uart: RTL



---
 rtl/sio_fifo_uart.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sio_fifo_uart.sv
// sio_fifo_uart: Z80 I/O-mapped 8N1 UART with TX/RX FIFOs, sticky OVR/FERR,
// loopback and a registered interrupt; generates its own 16x oversample tick.
//
// state    | meaning
// TX_IDLE  | line high; leaves on a tick with data queued, popping the head
// TX_START | start bit (0) for 16 ticks
// TX_DATA  | 8 data bits LSB first, 16 ticks each
// TX_STOP  | stop bit (1) for 16 ticks, then next byte or idle
// RX_IDLE  | hunting for a low sample on a tick (after a framing error, waits for high first)
// RX_START | 8 ticks to mid start bit; high there means glitch
// RX_DATA  | sample each bit at its centre, LSB first
// RX_STOP  | check stop bit; push byte, set OVR or set FERR
module sio_fifo_uart #(
    parameter int BAUD_DIV = 326,
    parameter int TX_AW    = 4,
    parameter int RX_AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       rd,
    input  logic       wr,
    input  logic       cd,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic [TX_AW:0] TX_ONE    = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0] RX_ONE    = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [15:0]    BAUD_LAST = 16'(BAUD_DIV - 1);

    logic wr_act, rd_act, wr_stb, rd_end, data_wr, ctrl_wr, flush, rx_pop, stat_clr;
    logic wr_prev_q, rd_prev_q, rd_cd_q, rd_cd_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic ctrl_unused;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic tick;

    logic [TX_AW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [7:0] tx_mem_q [2**TX_AW];
    logic tx_empty, tx_full, tx_push, tx_pop, tx_pop_ok;
    logic [7:0] tx_rdata;

    logic [RX_AW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [7:0] rx_mem_q [2**RX_AW];
    logic rx_empty, rx_full, rx_push, rx_pop_ok;

    tx_state_t tx_state_q, tx_state_d;
    logic [3:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic tx_line_q, tx_line_d;

    rx_state_t rx_state_q, rx_state_d;
    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_hold_q, rx_hold_d, rx_s1_q, rx_s2_q, rx_in, rx_done, ferr_set;

    logic ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic [7:0] status;

    // Strobes are levels: writes act on their rising edge, reads on their falling edge.
    assign wr_act      = ce & wr;
    assign rd_act      = ce & rd;
    assign wr_stb      = wr_act & ~wr_prev_q;
    assign rd_end      = rd_prev_q & ~rd_act;
    assign data_wr     = wr_stb & ~cd;
    assign ctrl_wr     = wr_stb & cd;
    assign flush       = ctrl_wr & data_in[7];
    assign rx_pop      = rd_end & ~rd_cd_q;
    assign stat_clr    = rd_end & rd_cd_q;
    assign ctrl_unused = ^data_in[6:3];
    assign tick        = (baud_cnt_q == BAUD_LAST);

    assign tx_empty  = (tx_wp_q == tx_rp_q);
    assign tx_full   = (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]) & (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]);
    assign tx_push   = data_wr & ~tx_full & ~flush;
    assign tx_pop_ok = tx_pop & ~tx_empty & ~flush;
    assign tx_rdata  = tx_mem_q[tx_rp_q[TX_AW-1:0]];

    assign rx_empty  = (rx_wp_q == rx_rp_q);
    assign rx_full   = (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]) & (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]);
    assign rx_push   = rx_done & ~rx_full & ~flush;
    assign rx_pop_ok = rx_pop & ~rx_empty & ~flush;
    assign rx_in     = ctrl_q[2] ? tx_line_q : rx_s2_q;

    assign status = {3'b000, ferr_q, ovr_q, tx_empty & (tx_state_q == TX_IDLE), ~tx_full, ~rx_empty};
    assign txd    = tx_line_q | ctrl_q[2];
    assign irq    = irq_q;

    always_comb begin
        data_out = 8'h00;
        if (rd_act) begin
            if (cd)
                data_out = status;
            else if (!rx_empty)
                data_out = rx_mem_q[rx_rp_q[RX_AW-1:0]];
        end
    end

    always_comb begin
        rd_cd_d    = rd_act ? cd : rd_cd_q;
        ctrl_d     = ctrl_wr ? data_in[2:0] : ctrl_q;
        baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
        // Error set beats the clear from a status read or flush.
        ovr_d      = (ovr_q & ~(stat_clr | flush)) | (rx_done & rx_full);
        ferr_d     = (ferr_q & ~(stat_clr | flush)) | ferr_set;
        irq_d      = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & ~tx_full);
        tx_wp_d    = tx_wp_q;
        tx_rp_d    = tx_rp_q;
        rx_wp_d    = rx_wp_q;
        rx_rp_d    = rx_rp_q;
        if (flush) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
            rx_wp_d = '0;
            rx_rp_d = '0;
        end else begin
            if (tx_push)   tx_wp_d = tx_wp_q + TX_ONE;
            if (tx_pop_ok) tx_rp_d = tx_rp_q + TX_ONE;
            if (rx_push)   rx_wp_d = rx_wp_q + RX_ONE;
            if (rx_pop_ok) rx_rp_d = rx_rp_q + RX_ONE;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tick) begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_state_d = TX_START;
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_rdata;
                        tx_cnt_d   = 4'd15;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == 4'd0) begin
                        tx_state_d = TX_DATA;
                        tx_cnt_d   = 4'd15;
                        tx_bit_d   = 3'd0;
                    end else
                        tx_cnt_d = tx_cnt_q - 4'd1;
                end
                TX_DATA: begin
                    if (tx_cnt_q == 4'd0) begin
                        tx_cnt_d = 4'd15;
                        if (tx_bit_q == 3'd7)
                            tx_state_d = TX_STOP;
                        else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        end
                    end else
                        tx_cnt_d = tx_cnt_q - 4'd1;
                end
                default: begin
                    if (tx_cnt_q == 4'd0) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (!tx_empty) begin
                            tx_state_d = TX_START;
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_rdata;
                            tx_cnt_d   = 4'd15;
                        end else
                            tx_state_d = TX_IDLE;
                    end else
                        tx_cnt_d = tx_cnt_q - 4'd1;
                end
            endcase
        end
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_hold_d  = rx_hold_q;
        rx_done    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_hold_q) begin
                    if (rx_in) rx_hold_d = 1'b0;
                end else if (tick && !rx_in) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = 4'd7;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt_q == 4'd0) begin
                        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                        rx_cnt_d   = 4'd15;
                        rx_bit_d   = 3'd0;
                    end else
                        rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt_q == 4'd0) begin
                        rx_shift_d = {rx_in, rx_shift_q[7:1]};
                        rx_cnt_d   = 4'd15;
                        if (rx_bit_q == 3'd7)
                            rx_state_d = RX_STOP;
                        else
                            rx_bit_d = rx_bit_q + 3'd1;
                    end else
                        rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
            default: begin
                if (tick) begin
                    if (rx_cnt_q == 4'd0) begin
                        rx_state_d = RX_IDLE;
                        rx_done    = rx_in;
                        ferr_set   = ~rx_in;
                        rx_hold_d  = ~rx_in;
                    end else
                        rx_cnt_d = rx_cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev_q  <= 1'b0;
            rd_prev_q  <= 1'b0;
            rd_cd_q    <= 1'b0;
            ctrl_q     <= 3'b000;
            baud_cnt_q <= 16'd0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_hold_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_prev_q  <= wr_act;
            rd_prev_q  <= rd_act;
            rd_cd_q    <= rd_cd_d;
            ctrl_q     <= ctrl_d;
            baud_cnt_q <= baud_cnt_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_hold_q  <= rx_hold_d;
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= data_in;
        if (rx_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_shift_q;
    end

endmodule
